fp16_align_addsub: RTL

- Front stage of the 16-bit half-precision adder/subtractor. It accepts two IEEE-754 binary16 operands and an add/sub select.
- It aligns the smaller-exponent significand with an iterative one-bit-per-cycle shifter, then forms the signed sum.
- It hands the normalization stage a 14-bit two's-complement mantissa (bit 13 = sign) and a 5-bit exponent.
- A valid/ready handshake is used on both sides.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_unpack.sv | 40 ++++
 rtl/fp16_align_addsub.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared widths, limits and FSM encoding for the fp16 align/add front stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = 12;   // hidden + fraction + guard
  localparam int MANT_W = 14;   // SIG_W plus carry and sign headroom

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  localparam int SHIFT_CAP_DEF  = 12;
  localparam int GUARD_BITS_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_unpack.sv
// Splits one binary16 operand into sign, effective exponent and significand.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   op_i       binary16 operand
//   flip_i     inverts the sign (used for subtraction on operand B)
//   sign_o     effective sign
//   exp_eff_o  exponent, with subnormals (e==0) mapped to 1
//   sig_o      {hidden, fraction, guard zeros}
//   special_o  exponent field is all ones (Inf/NaN)
module fp16_unpack
  import fp16_pkg::*;
#(
  parameter int GUARD_BITS = GUARD_BITS_DEF
) (
  input  logic [15:0]      op_i,
  input  logic             flip_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_eff_o,
  output logic [SIG_W-1:0] sig_o,
  output logic             special_o
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac;
  logic              hidden;

  always_comb begin
    exp_raw   = op_i[14:10];
    frac      = op_i[9:0];
    hidden    = (exp_raw != '0);
    sign_o    = op_i[15] ^ flip_i;
    // A subnormal shares the weight of exponent 1, just without the hidden bit.
    exp_eff_o = hidden ? exp_raw : EXP_W'(1);
    sig_o     = {hidden, frac, {GUARD_BITS{1'b0}}};
    special_o = (exp_raw == EXP_MAX);
  end

endmodule

// File: rtl/fp16_align_addsub.sv
// Aligns two binary16 operands with a 1-bit/cycle shifter and forms the signed sum.
// Latency: 2 + min(exp diff, SHIFT_CAP) cycles after accept; 1 cycle for Inf/NaN inputs.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until consumed.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      operand handshake (op_a, op_b, sub)
//   out_valid/out_ready    result handshake (mantisa, exp, special_flag)
//   mantisa                14-bit two's-complement sum, hidden-bit weight at bit 11
//   exp                    exponent of the larger operand (31 on special inputs)
//   special_flag           an input was Inf/NaN
module fp16_align_addsub
  import fp16_pkg::*;
#(
  parameter int SHIFT_CAP  = SHIFT_CAP_DEF,
  parameter int GUARD_BITS = GUARD_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       op_a,
  input  logic [15:0]       op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mantisa,
  output logic [EXP_W-1:0]  exp,
  output logic              special_flag
);

  localparam int CNT_W = $clog2(SHIFT_CAP + 1);

  // Unpacked operands
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             spec_a, spec_b;

  fp16_unpack #(.GUARD_BITS(GUARD_BITS)) u_unpack_a (
    .op_i      (op_a),
    .flip_i    (1'b0),
    .sign_o    (sign_a),
    .exp_eff_o (exp_a),
    .sig_o     (sig_a),
    .special_o (spec_a)
  );

  fp16_unpack #(.GUARD_BITS(GUARD_BITS)) u_unpack_b (
    .op_i      (op_b),
    .flip_i    (sub),
    .sign_o    (sign_b),
    .exp_eff_o (exp_b),
    .sig_o     (sig_b),
    .special_o (spec_b)
  );

  // State and datapath registers
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIG_W-1:0]  big_sig_q, big_sig_d;
  logic [SIG_W-1:0]  small_sig_q, small_sig_d;
  logic              big_sign_q, big_sign_d;
  logic              small_sign_q, small_sign_d;
  logic [EXP_W-1:0]  exp_big_q, exp_big_d;
  logic              spec_pend_q, spec_pend_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              flag_q, flag_d;

  // Swap selection and shift-count computation
  logic             a_big;
  logic [EXP_W-1:0] diff;
  logic [CNT_W-1:0] cnt_load;
  logic [MANT_W-1:0] big_ext, small_ext, big_term, small_term;

  always_comb begin
    a_big    = (exp_a >= exp_b);  // tie keeps A as the big operand
    diff     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    // Past SHIFT_CAP every significand bit has been shifted out anyway.
    cnt_load = (int'(diff) > SHIFT_CAP) ? CNT_W'(SHIFT_CAP) : CNT_W'(diff);

    big_ext    = {2'b00, big_sig_q};
    small_ext  = {2'b00, small_sig_q};
    big_term   = big_sign_q   ? (-big_ext)   : big_ext;
    small_term = small_sign_q ? (-small_ext) : small_ext;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    big_sig_d    = big_sig_q;
    small_sig_d  = small_sig_q;
    big_sign_d   = big_sign_q;
    small_sign_d = small_sign_q;
    exp_big_d    = exp_big_q;
    spec_pend_d  = spec_pend_q;
    mant_d       = mant_q;
    exp_d        = exp_q;
    flag_d       = flag_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          big_sig_d    = a_big ? sig_a  : sig_b;
          small_sig_d  = a_big ? sig_b  : sig_a;
          big_sign_d   = a_big ? sign_a : sign_b;
          small_sign_d = a_big ? sign_b : sign_a;
          exp_big_d    = a_big ? exp_a  : exp_b;
          cnt_d        = cnt_load;
          spec_pend_d  = spec_a | spec_b;
          flag_d       = 1'b0;
          state_d      = ALIGN;
        end
      end

      ALIGN: begin
        if (spec_pend_q) begin
          // Inf/NaN: no arithmetic, publish the marker payload one edge after accept.
          mant_d  = '0;
          exp_d   = EXP_MAX;
          flag_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          state_d = ADD;
        end else begin
          // Truncating shift: bits falling off the guard position are dropped.
          small_sig_d = small_sig_q >> 1;
          cnt_d       = cnt_q - CNT_W'(1);
        end
      end

      ADD: begin
        mant_d  = big_term + small_term;
        exp_d   = exp_big_q;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      big_sig_q    <= '0;
      small_sig_q  <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      exp_big_q    <= '0;
      spec_pend_q  <= 1'b0;
      mant_q       <= '0;
      exp_q        <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      big_sig_q    <= big_sig_d;
      small_sig_q  <= small_sig_d;
      big_sign_q   <= big_sign_d;
      small_sign_q <= small_sign_d;
      exp_big_q    <= exp_big_d;
      spec_pend_q  <= spec_pend_d;
      mant_q       <= mant_d;
      exp_q        <= exp_d;
      flag_q       <= flag_d;
    end
  end

  // in_ready depends only on state (and reset), never on out_ready.
  assign in_ready     = rst_n && (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign mantisa      = mant_q;
  assign exp          = exp_q;
  assign special_flag = flag_q;

endmodule
